uart_host_sequencer: RTL
========================

Name: uart_host_sequencer

Overview:
- Host-side counterpart of the UART ALU endpoint.
- Accepts a request carrying operand A, operand B and opcode, and serialises them as three bytes in the order A, B, opcode. It drives an external transmitter through its start/done handshake.
- Then waits for the single result byte from an external receiver and presents it, or flags a timeout.
- Sits between bench/user logic and the transmitter/receiver pair; shares their baud tick domain only through the handshakes.

Parameters:
- DBIT, 8, byte width of operands, opcode, result and tx/rx data.
- TO_W, 16, width of the response timeout counter.
- TIMEOUT, 50000, clock cycles allowed in WAIT_RX before timeout (must be < 2**TO_W).

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req  in  1  request; sampled only in IDLE.
- i_op_a  in  DBIT  operand A.
- i_op_b  in  DBIT  operand B.
- i_opcode  in  DBIT  operation code.
- o_busy  out  1  high from request accept until o_valid/o_timeout cycle inclusive.
- o_tx_start  out  1  one-cycle start pulse to transmitter.
- o_tx_data  out  DBIT  byte for transmitter; stable from o_tx_start until i_tx_done.
- i_tx_done  in  1  transmitter done tick.
- i_rx_done  in  1  receiver done tick.
- i_rx_data  in  DBIT  received byte, valid with i_rx_done.
- o_result  out  DBIT  last accepted result; holds until next result.
- o_valid  out  1  one-cycle pulse: o_result updated.
- o_timeout  out  1  one-cycle pulse: no response within TIMEOUT.

Behaviour:
- Reset (i_reset=0, async): state IDLE; every output 0; byte index 0; timer 0; latched operands 0.
- States and transitions:
  - IDLE: on i_req=1, latch A, B and opcode; set index=0; o_busy=1; go to LOAD. Operand changes after accept have no effect.
  - LOAD: drive o_tx_data from the latched byte at index; pulse o_tx_start for exactly one cycle; go to WAIT_TX.
  - WAIT_TX: wait for i_tx_done. If index<2, increment index and go to LOAD. If index=2, clear the timer and go to WAIT_RX.
  - WAIT_RX: timer increments each cycle.
    - i_rx_done=1: o_result<=i_rx_data; o_valid pulse; go to DONE.
    - Timer reaches TIMEOUT-1 with no i_rx_done: o_timeout pulse; go to DONE.
  - DONE: o_busy deasserts; next cycle in IDLE.
- Latency: i_req accepted at edge N -> o_tx_start high during cycle N+1. i_tx_done of the final byte -> WAIT_RX the next cycle.
- i_rx_done in any state other than WAIT_RX is ignored: stale or echo bytes are discarded, o_result is unchanged.
- i_rx_done on the same cycle as the timeout limit: the result wins (o_valid=1, o_timeout=0).
- i_req while busy is ignored; no queuing.
- i_tx_done outside WAIT_TX is ignored.
- o_valid and o_timeout are never both high. Each pulses at most once per transaction.
- Reset asserted mid-transaction aborts immediately; no partial pulse is emitted after release.

Optional Feature:
- UART_HOST_RETRY_EN defined: on the first timeout of a transaction, suppress o_timeout, reset index=0 and re-send all three bytes (LOAD). A second timeout pulses o_timeout. The retry flag clears on every new accept.
- Undefined: the first timeout pulses o_timeout directly; there is no retry state.

Decomposition:
- Package uart_host_pkg: state encoding (IDLE, LOAD, WAIT_TX, WAIT_RX, DONE) and byte-index constants (IDX_A=0, IDX_B=1, IDX_OP=2).
- One sub-module, uart_host_timer: clear, enable, TO_W counter, terminal-count flag at TIMEOUT-1.

Test Plan:
- Nominal transaction:
  - Stimulus: A=0x05, B=0x03, opcode=0x20; model tx_done 10 cycles after each start; rx_done with 0x08 twenty cycles later.
  - Response: three o_tx_start pulses carrying 0x05, 0x03, 0x20 in order; o_result=0x08; one o_valid pulse; o_busy returns to 0.
- Timeout (TIMEOUT=100):
  - Stimulus: no rx_done after the third tx_done.
  - Response: o_timeout pulses exactly 100 cycles after entering WAIT_RX; o_valid stays 0; o_result keeps its previous value.
- Spurious receive:
  - Stimulus: rx_done with 0xAA during WAIT_TX of byte B.
  - Response: ignored; later rx_done with 0x11 gives o_result=0x11.
- Busy and collision:
  - Stimulus 1: i_req while o_busy=1 → no new transaction.
  - Stimulus 2: rx_done on the timeout cycle → o_valid=1, o_timeout=0.
- Mid-operation reset:
  - Stimulus: i_reset=0 during WAIT_TX of byte B.
  - Response: all outputs 0 asynchronously; after release, a new i_req restarts from byte A (0x05).
- UART_HOST_RETRY_EN:
  - Stimulus: first attempt times out.
  - Response: bytes 0x05, 0x03, 0x20 are re-sent; the second attempt gets rx 0x08 → o_valid pulses and o_timeout is never asserted.

Source files
------------

// File: rtl/uart_host_pkg.sv
// Shared types for the UART host sequencer: FSM state encoding and the
// position of each request byte in the transmit order.
package uart_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_TX,
    WAIT_RX,
    DONE
  } state_t;

  localparam logic [1:0] IDX_A  = 2'd0;
  localparam logic [1:0] IDX_B  = 2'd1;
  localparam logic [1:0] IDX_OP = 2'd2;

endpackage

// File: rtl/uart_host_sequencer_if.sv
// Request/response and transmitter/receiver handshake bundle of the UART
// host sequencer. The master modport is the sequencer's view; the slave
// modport is the view of the user logic and the tx/rx pair around it.
interface uart_host_sequencer_if #(
  parameter int DBIT = 8
);
  logic            i_req;
  logic [DBIT-1:0] i_op_a;
  logic [DBIT-1:0] i_op_b;
  logic [DBIT-1:0] i_opcode;
  logic            o_busy;
  logic            o_tx_start;
  logic [DBIT-1:0] o_tx_data;
  logic            i_tx_done;
  logic            i_rx_done;
  logic [DBIT-1:0] i_rx_data;
  logic [DBIT-1:0] o_result;
  logic            o_valid;
  logic            o_timeout;

  modport master (
    input  i_req, i_op_a, i_op_b, i_opcode, i_tx_done, i_rx_done, i_rx_data,
    output o_busy, o_tx_start, o_tx_data, o_result, o_valid, o_timeout
  );

  modport slave (
    output i_req, i_op_a, i_op_b, i_opcode, i_tx_done, i_rx_done, i_rx_data,
    input  o_busy, o_tx_start, o_tx_data, o_result, o_valid, o_timeout
  );

endinterface

// File: rtl/uart_host_timer.sv
// Response timer: counts enabled cycles from a synchronous clear and flags
// the terminal count TIMEOUT-1 combinationally.
module uart_host_timer #(
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  logic [TO_W-1:0] cnt;

  // Cycle counter; clear has priority over counting.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt <= '0;
    end else if (i_clear) begin
      cnt <= '0;
    end else if (i_enable) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign o_tc = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/uart_host_sequencer.sv
// UART host sequencer: sends operand A, operand B and opcode as three bytes
// through the transmitter handshake, then waits for one result byte from the
// receiver or reports a timeout.
// Optional feature macro: UART_HOST_RETRY_EN -- the first timeout of a
// transaction re-sends all three bytes instead of reporting; a second
// timeout is reported.
module uart_host_sequencer
  import uart_host_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  uart_host_sequencer_if.master bus
);

  state_t          state;
  logic [1:0]      idx;
  logic [DBIT-1:0] op_a;
  logic [DBIT-1:0] op_b;
  logic [DBIT-1:0] opcode;
  logic            tmr_clear;
  logic            tmr_en;
  logic            tmr_tc;
`ifdef UART_HOST_RETRY_EN
  logic            retried;
`endif

  function automatic logic [DBIT-1:0] pick_byte(input logic [1:0] i,
                                                input logic [DBIT-1:0] a,
                                                input logic [DBIT-1:0] b,
                                                input logic [DBIT-1:0] op);
    case (i)
      IDX_A:   pick_byte = a;
      IDX_B:   pick_byte = b;
      default: pick_byte = op;
    endcase
  endfunction

  // The timer restarts on the done tick of the last byte and runs only while
  // the response is awaited.
  assign tmr_clear = (state == WAIT_TX) && bus.i_tx_done && (idx == IDX_OP);
  assign tmr_en    = (state == WAIT_RX);

  uart_host_timer #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (tmr_clear),
    .i_enable (tmr_en),
    .o_tc     (tmr_tc)
  );

  // Transaction FSM. Start/valid/timeout are registered one-cycle pulses;
  // o_tx_start is raised on the edge that enters LOAD, so it is high exactly
  // during the LOAD cycle and o_tx_data is already stable with it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state          <= IDLE;
      idx            <= IDX_A;
      op_a           <= '0;
      op_b           <= '0;
      opcode         <= '0;
      bus.o_busy     <= 1'b0;
      bus.o_tx_start <= 1'b0;
      bus.o_tx_data  <= '0;
      bus.o_result   <= '0;
      bus.o_valid    <= 1'b0;
      bus.o_timeout  <= 1'b0;
`ifdef UART_HOST_RETRY_EN
      retried        <= 1'b0;
`endif
    end else begin
      bus.o_tx_start <= 1'b0;
      bus.o_valid    <= 1'b0;
      bus.o_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req) begin
            op_a           <= bus.i_op_a;
            op_b           <= bus.i_op_b;
            opcode         <= bus.i_opcode;
            idx            <= IDX_A;
            bus.o_busy     <= 1'b1;
            bus.o_tx_data  <= bus.i_op_a;
            bus.o_tx_start <= 1'b1;
`ifdef UART_HOST_RETRY_EN
            retried        <= 1'b0;
`endif
            state          <= LOAD;
          end
        end
        LOAD: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (bus.i_tx_done) begin
            if (idx != IDX_OP) begin
              idx            <= idx + 2'd1;
              bus.o_tx_data  <= pick_byte(idx + 2'd1, op_a, op_b, opcode);
              bus.o_tx_start <= 1'b1;
              state          <= LOAD;
            end else begin
              state <= WAIT_RX;
            end
          end
        end
        WAIT_RX: begin
          // A result on the terminal-count cycle still counts as a result.
          if (bus.i_rx_done) begin
            bus.o_result <= bus.i_rx_data;
            bus.o_valid  <= 1'b1;
            state        <= DONE;
          end else if (tmr_tc) begin
`ifdef UART_HOST_RETRY_EN
            if (!retried) begin
              retried        <= 1'b1;
              idx            <= IDX_A;
              bus.o_tx_data  <= op_a;
              bus.o_tx_start <= 1'b1;
              state          <= LOAD;
            end else begin
              bus.o_timeout <= 1'b1;
              state         <= DONE;
            end
`else
            bus.o_timeout <= 1'b1;
            state         <= DONE;
`endif
          end
        end
        DONE: begin
          bus.o_busy <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
